// File: rtl/vd_pkg.sv
// rtl/vd_pkg.sv - shared Viterbi decoder constants, bank codes and write-side FSM states
package vd_pkg;

  // Survivor memory geometry, shared with the traceback side
  localparam int DEPTH_DEF  = 1024;
  localparam int ADDR_W_DEF = 10;

  // Width of one ACS decision vector (one bit per trellis state)
  localparam int DV_W = 64;

  // Bank encodings as carried on mem_bank
  localparam logic [1:0] BANK_A = 2'd0;
  localparam logic [1:0] BANK_B = 2'd1;
  localparam logic [1:0] BANK_C = 2'd2;
  localparam logic [1:0] BANK_D = 2'd3;

  // Write-side fill tracking: traceback data is meaningful only in RUN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL0 = 2'd1,
    ST_FILL1 = 2'd2,
    ST_RUN   = 2'd3
  } wr_state_t;

endpackage

// File: rtl/sm_addr_gen.sv
// rtl/sm_addr_gen.sv - survivor write counters, bank rotation and mirrored read address
module sm_addr_gen
  import vd_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              valid_in,
  output logic [ADDR_W-1:0] addr_wr,
  output logic [ADDR_W-1:0] addr_rd,
  output logic [1:0]        bank_cnt,
  output logic [1:0]        mem_bank,
  output logic              wrap,
  output logic              bank_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] wr_cnt;

  // Current write is the last slot of the bank
  assign wrap = (wr_cnt == LAST_ADDR);

  // Counters advance only on accepted vectors; the read address is the
  // complement of the write counter since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (RST) begin
      wr_cnt    <= '0;
      bank_cnt  <= BANK_A;
      addr_wr   <= '0;
      addr_rd   <= LAST_ADDR;
      mem_bank  <= BANK_A;
      bank_done <= 1'b0;
    end else if (valid_in) begin
      addr_wr   <= wr_cnt;
      addr_rd   <= ~wr_cnt;
      mem_bank  <= bank_cnt;
      bank_done <= wrap;
      wr_cnt    <= wr_cnt + ADDR_W'(1);
      if (wrap) begin
        bank_cnt <= bank_cnt + 2'd1;
      end
    end else begin
      bank_done <= 1'b0;
    end
  end

endmodule

// File: rtl/survivor_mem_wr_ctrl.sv
// rtl/survivor_mem_wr_ctrl.sv - write-side controller for the four survivor memory banks
module survivor_mem_wr_ctrl
  import vd_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              valid_in,
  input  logic [DV_W-1:0]   d_in,
  output logic [DV_W-1:0]   d_i_mem,
  output logic [ADDR_W-1:0] addr_wr,
  output logic              wr_en_A,
  output logic              wr_en_B,
  output logic              wr_en_C,
  output logic              wr_en_D,
  output logic [ADDR_W-1:0] addr_rd,
  output logic [1:0]        mem_bank,
  output logic              bank_done,
  output logic              tb_ready
);

  wr_state_t   state_q;
  wr_state_t   state_d;
  logic [1:0]  bank_cnt;
  logic        wrap;
  logic [3:0]  wr_en_d;

  sm_addr_gen #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .RST       (RST),
    .valid_in  (valid_in),
    .addr_wr   (addr_wr),
    .addr_rd   (addr_rd),
    .bank_cnt  (bank_cnt),
    .mem_bank  (mem_bank),
    .wrap      (wrap),
    .bank_done (bank_done)
  );

  // Fill tracking: two complete banks must exist before traceback is valid
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (valid_in)         state_d = ST_FILL0;
      ST_FILL0: if (valid_in && wrap) state_d = ST_FILL1;
      ST_FILL1: if (valid_in && wrap) state_d = ST_RUN;
      ST_RUN:                         state_d = ST_RUN;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // One-hot strobe for the bank being written this cycle
  always_comb begin
    wr_en_d = 4'b0000;
    if (valid_in) begin
      case (bank_cnt)
        BANK_A:  wr_en_d = 4'b0001;
        BANK_B:  wr_en_d = 4'b0010;
        BANK_C:  wr_en_d = 4'b0100;
        BANK_D:  wr_en_d = 4'b1000;
        default: wr_en_d = 4'b0000;
      endcase
    end
  end

  // State, ready flag, strobes and write data registers
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      tb_ready <= 1'b0;
      d_i_mem  <= '0;
      wr_en_A  <= 1'b0;
      wr_en_B  <= 1'b0;
      wr_en_C  <= 1'b0;
      wr_en_D  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tb_ready <= (state_q == ST_RUN);
      wr_en_A  <= wr_en_d[0];
      wr_en_B  <= wr_en_d[1];
      wr_en_C  <= wr_en_d[2];
      wr_en_D  <= wr_en_d[3];
      if (valid_in) begin
        d_i_mem <= d_in;
      end
    end
  end

endmodule

// File: tb/tb_survivor_mem_wr_ctrl.sv
// tb/tb_survivor_mem_wr_ctrl.sv - directed self-checking bench for survivor_mem_wr_ctrl
module tb_survivor_mem_wr_ctrl;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk;
  logic              RST;
  logic              valid_in;
  logic [63:0]       d_in;
  logic [63:0]       d_i_mem;
  logic [ADDR_W-1:0] addr_wr;
  logic              wr_en_A;
  logic              wr_en_B;
  logic              wr_en_C;
  logic              wr_en_D;
  logic [ADDR_W-1:0] addr_rd;
  logic [1:0]        mem_bank;
  logic              bank_done;
  logic              tb_ready;

  int checks = 0;
  int errors = 0;

  survivor_mem_wr_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .valid_in  (valid_in),
    .d_in      (d_in),
    .d_i_mem   (d_i_mem),
    .addr_wr   (addr_wr),
    .wr_en_A   (wr_en_A),
    .wr_en_B   (wr_en_B),
    .wr_en_C   (wr_en_C),
    .wr_en_D   (wr_en_D),
    .addr_rd   (addr_rd),
    .mem_bank  (mem_bank),
    .bank_done (bank_done),
    .tb_ready  (tb_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic r, input logic v, input logic [63:0] d);
    RST      = r;
    valid_in = v;
    d_in     = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input int b);
    logic [3:0] one;
    one = 4'b0001;
    return one << b;
  endfunction

  task automatic do_reset();
    step(1'b1, 1'b0, 64'h0);
    step(1'b0, 1'b0, 64'h0);
  endtask

  logic [3:0] wr_en_v;
  assign wr_en_v = {wr_en_D, wr_en_C, wr_en_B, wr_en_A};

  initial begin
    RST      = 1'b0;
    valid_in = 1'b0;
    d_in     = '0;
    #2;

    // Reset held two cycles while valid_in is high: vectors dropped
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_d_i_mem",   d_i_mem,   64'h0);
    chk("rst_addr_wr",   addr_wr,   64'd0);
    chk("rst_addr_rd",   addr_rd,   64'd7);
    chk("rst_wr_en",     wr_en_v,   64'h0);
    chk("rst_mem_bank",  mem_bank,  64'd0);
    chk("rst_bank_done", bank_done, 64'd0);
    chk("rst_tb_ready",  tb_ready,  64'd0);

    // Fill bank A with d_in = k
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 64'(k));
      chk($sformatf("fill_wr_en[%0d]", k),     wr_en_v,   64'h1);
      chk($sformatf("fill_addr_wr[%0d]", k),   addr_wr,   64'(k));
      chk($sformatf("fill_addr_rd[%0d]", k),   addr_rd,   64'(7 - k));
      chk($sformatf("fill_d_i_mem[%0d]", k),   d_i_mem,   64'(k));
      chk($sformatf("fill_bank_done[%0d]", k), bank_done, 64'(k == 7));
      chk($sformatf("fill_mem_bank[%0d]", k),  mem_bank,  64'd0);
    end

    // Continuous stream of 40 vectors from a clean start
    do_reset();
    for (int n = 0; n < 40; n++) begin
      step(1'b0, 1'b1, 64'h1000 + 64'(n));
      chk($sformatf("strm_mem_bank[%0d]", n),  mem_bank,  64'((n / 8) % 4));
      chk($sformatf("strm_wr_en[%0d]", n),     wr_en_v,   64'(onehot((n / 8) % 4)));
      chk($sformatf("strm_addr_wr[%0d]", n),   addr_wr,   64'(n % 8));
      chk($sformatf("strm_addr_rd[%0d]", n),   addr_rd,   64'(7 - (n % 8)));
      chk($sformatf("strm_bank_done[%0d]", n), bank_done, 64'((n % 8) == 7));
      chk($sformatf("strm_tb_ready[%0d]", n),  tb_ready,  64'(n >= 16));
    end

    // Gap pattern 1,0,0,1
    do_reset();
    step(1'b0, 1'b1, 64'hA1);
    chk("gap0_wr_en",   wr_en_v, 64'h1);
    chk("gap0_addr_wr", addr_wr, 64'd0);
    chk("gap0_d_i_mem", d_i_mem, 64'hA1);
    for (int g = 1; g <= 2; g++) begin
      step(1'b0, 1'b0, 64'hDEAD_BEEF);
      chk($sformatf("gap%0d_wr_en", g),     wr_en_v,   64'h0);
      chk($sformatf("gap%0d_addr_wr", g),   addr_wr,   64'd0);
      chk($sformatf("gap%0d_addr_rd", g),   addr_rd,   64'd7);
      chk($sformatf("gap%0d_d_i_mem", g),   d_i_mem,   64'hA1);
      chk($sformatf("gap%0d_bank_done", g), bank_done, 64'd0);
    end
    step(1'b0, 1'b1, 64'hB2);
    chk("gap3_wr_en",   wr_en_v, 64'h1);
    chk("gap3_addr_wr", addr_wr, 64'd1);
    chk("gap3_addr_rd", addr_rd, 64'd6);
    chk("gap3_d_i_mem", d_i_mem, 64'hB2);

    // Reset on the 13th write (bank B, addr 4)
    do_reset();
    for (int n = 0; n < 12; n++) step(1'b0, 1'b1, 64'(n));
    chk("mid_pre_mem_bank", mem_bank, 64'd1);
    chk("mid_pre_addr_wr",  addr_wr,  64'd3);
    step(1'b1, 1'b1, 64'h55);
    chk("mid_rst_wr_en",    wr_en_v,  64'h0);
    chk("mid_rst_addr_wr",  addr_wr,  64'd0);
    chk("mid_rst_mem_bank", mem_bank, 64'd0);
    for (int m = 0; m < 17; m++) begin
      step(1'b0, 1'b1, 64'h200 + 64'(m));
      chk($sformatf("mid_mem_bank[%0d]", m), mem_bank, 64'(m / 8));
      chk($sformatf("mid_addr_wr[%0d]", m),  addr_wr,  64'(m % 8));
      chk($sformatf("mid_tb_ready[%0d]", m), tb_ready, 64'(m >= 16));
    end

    // Reset collides with the last write of bank A
    do_reset();
    for (int n = 0; n < 7; n++) step(1'b0, 1'b1, 64'(n));
    chk("col_pre_addr_wr", addr_wr, 64'd6);
    step(1'b1, 1'b1, 64'h77);
    chk("col_bank_done", bank_done, 64'd0);
    chk("col_mem_bank",  mem_bank,  64'd0);
    chk("col_wr_en",     wr_en_v,   64'h0);
    chk("col_addr_wr",   addr_wr,   64'd0);
    step(1'b0, 1'b1, 64'h88);
    chk("col_post_mem_bank",  mem_bank,  64'd0);
    chk("col_post_addr_wr",   addr_wr,   64'd0);
    chk("col_post_wr_en",     wr_en_v,   64'h1);
    chk("col_post_bank_done", bank_done, 64'd0);
    chk("col_post_d_i_mem",   d_i_mem,   64'h88);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/survivor_mem_wr_ctrl.md
# survivor_mem_wr_ctrl

Write-side controller for the four survivor-path memory banks (A–D) of the Viterbi decoder. It accepts one 64-bit ACS decision vector per valid cycle and writes it into the current bank at an ascending address. It rotates the bank index on each bank wrap and supplies the descending shared read address and the `mem_bank` index consumed by the traceback top. It is the producer end of the bank-rotation scheme that the traceback units read from.

## Interface
- `DEPTH`, 1024: decision vectors per bank (= traceback length); power of two, ≥ 4
- `ADDR_W`, 10: log2(`DEPTH`)
- `clk` in 1: single clock, all logic on rising edge
- `RST` in 1: reset, synchronous, active-high
- `valid_in` in 1: `d_in` carries a decision vector this cycle
- `d_in` in 64: ACS decision bits, bit i = survivor decision of state i
- `d_i_mem` out 64: registered write data, common to all banks
- `addr_wr` out `ADDR_W`: write address, common to all banks
- `wr_en_A`, `wr_en_B`, `wr_en_C`, `wr_en_D` out 1 each: one-hot bank write strobes
- `addr_rd` out `ADDR_W`: read address for all banks, always `DEPTH-1-addr_wr`
- `mem_bank` out 2: bank targeted by the current write, 0=A … 3=D
- `bank_done` out 1: one-cycle pulse coincident with the last write (`addr_wr`=`DEPTH-1`) of a bank
- `tb_ready` out 1: at least two full banks have been written; traceback data is meaningful

## Operation
- Internal counters:
  - `wr_cnt` (`ADDR_W` bits)
  - `bank_cnt` (2 bits)
- FSM states: IDLE, FILL0, FILL1, RUN.
  - IDLE → FILL0 on the first accepted `valid_in`.
  - FILL0 → FILL1 when bank 0 completes.
  - FILL1 → RUN when bank 1 completes.
  - RUN is terminal until `RST`.
  - `tb_ready` = (state==RUN), registered.
- Accepted vector (`valid_in`=1):
  - `d_i_mem`<=`d_in`; `addr_wr`<=`wr_cnt`; `addr_rd`<=`DEPTH-1-wr_cnt`; `mem_bank`<=`bank_cnt`; `wr_en_X` for `bank_cnt` <=1, others <=0.
  - `wr_cnt` increments modulo `DEPTH`.
  - On `wr_cnt`==`DEPTH-1`: `bank_cnt` increments modulo 4 (3→0) and `bank_done`<=1.
- `valid_in`=0:
  - All `wr_en_*`<=0 and `bank_done`<=0.
  - `d_i_mem`, `addr_wr`, `addr_rd`, `mem_bank`, the counters and the state hold.
- Bank rotation never stalls. No overflow condition: the traceback side consumes in lockstep.
- Width rule: `addr_rd` is computed as the bitwise complement of `wr_cnt` (valid because `DEPTH` is a power of two). No carry logic.

## Timing
- Reset values (all outputs), one cycle after `RST` is sampled high: `d_i_mem`=0, `addr_wr`=0, `addr_rd`=`DEPTH-1`, `wr_en_*`=0, `mem_bank`=0, `bank_done`=0, `tb_ready`=0; state IDLE, counters 0.
- Latency: `valid_in`/`d_in` at edge t → `wr_en_*`, `addr_wr`, `addr_rd`, `mem_bank`, `d_i_mem` valid after edge t+1. All outputs are registered.
- `mem_bank` and `addr_rd` change in the same cycle. The traceback top's own 2-cycle `mem_bank` delay aligns it with the synchronous RAM read data.
- `tb_ready` rises in the cycle after the `bank_done` pulse of bank B (the second bank).
- `RST` together with `valid_in`: reset wins and the vector is dropped.
- `RST` mid-bank: counters, bank and FSM return to 0/IDLE. Partially written bank contents are not cleared; they are overwritten on refill.
- Back-to-back valid across a bank boundary: there is no bubble. Vector `DEPTH-1` goes to bank b, and the next vector goes to bank (b+1)%4 at address 0 on the next cycle.

## Structure
- Shared package `vd_pkg`:
  - `DEPTH`/`ADDR_W` defaults (shared with traceback)
  - Bank encodings `BANK_A`=2'd0 … `BANK_D`=2'd3
  - FSM state enum
  - 64-bit decision-vector width constant
- One sub-module, `sm_addr_gen`, containing:
  - `wr_cnt`/`bank_cnt` counters, wrap detect and `bank_done`
  - `addr_rd` derivation
- The top holds the FSM, write-enable decode and data register.

## Test plan
Bench uses `DEPTH`=8, `ADDR_W`=3.
- **Reset:** hold `RST` 2 cycles with `valid_in`=1 → all outputs at reset values, `addr_rd`=7, no `wr_en_*` asserted.
- **Fill one bank:** 8 consecutive vectors `d_in`=k → `wr_en_A` for 8 cycles, `addr_wr` 0..7, `addr_rd` 7..0, `d_i_mem`=k; `bank_done` only on `addr_wr`=7; `mem_bank`=0 throughout.
- **Continuous stream of 40 vectors:** `mem_bank` sequence A,B,C,D,A at 8-cycle steps with no bubble at boundaries; `tb_ready` rises one cycle after the 16th write and stays 1.
- **Gaps:** `valid_in` pattern 1,0,0,1 → `wr_en_*` low during the gap; `addr_wr` goes 0, holds, then 1; `d_i_mem` holds.
- **Reset mid-operation:** `RST` at write 13 (bank B, addr 4) → next accepted vector goes to bank A addr 0; `tb_ready`=0 until 16 further writes.
- **Reset/valid collision:** `RST`=1 with `valid_in`=1 on the last write of bank A → no `bank_done`, `mem_bank` stays 0.
